// File: rtl/clause_pkg.sv
// Shared definitions for the clause variable sequencer.
//   state_e     : sequencer FSM states.
//   index_width : output index width (the wider of the two index widths, at least 1).
//   count_width : width of the optional variable-count output.
package clause_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StLastEmpty
  } state_e;

  localparam int unsigned BoolCoefWidth = 2;

  function automatic int unsigned index_width(input int unsigned int_bits,
                                              input int unsigned bool_bits);
    int unsigned w;
    w = (int_bits > bool_bits) ? int_bits : bool_bits;
    return (w == 0) ? 1 : w;
  endfunction

  // Holds a popcount of NI+NB flags: log2(NI+NB)+1 bits.
  function automatic int unsigned count_width(input int unsigned int_bits,
                                              input int unsigned bool_bits);
    return $clog2((1 << int_bits) + (1 << bool_bits)) + 1;
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Lowest-set-bit priority encoder.
//   req_i   : request vector.
//   index_o : position of the lowest set bit of req_i (0 when none).
//   found_o : req_i has at least one bit set.
module lsb_priority_encoder #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] index_o,
  output logic            found_o
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        index_o = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/variables_detector.sv
// VariablesDetector: flags which variable slots of a clause are in use.
//   integer_coefficients_i : 2**IntIdxBits coefficients of IntCoefWidth bits each.
//   boolean_coefficients_i : 2**BoolIdxBits coefficients of BoolCoefWidth bits each.
//   integer_variables_o    : bit i set iff integer coefficient i is nonzero.
//   boolean_variables_o    : bit i set iff boolean coefficient i is nonzero.
// Purely combinational.
module VariablesDetector #(
  parameter int unsigned IntIdxBits    = 1,
  parameter int unsigned BoolIdxBits   = 1,
  parameter int unsigned IntCoefWidth  = 4,
  parameter int unsigned BoolCoefWidth = 2,
  localparam int unsigned NumInt  = 1 << IntIdxBits,
  localparam int unsigned NumBool = 1 << BoolIdxBits
) (
  input  logic [NumInt*IntCoefWidth-1:0]   integer_coefficients_i,
  input  logic [NumBool*BoolCoefWidth-1:0] boolean_coefficients_i,
  output logic [NumInt-1:0]                integer_variables_o,
  output logic [NumBool-1:0]               boolean_variables_o
);

  for (genvar g = 0; g < NumInt; g++) begin : g_int
    assign integer_variables_o[g] = |integer_coefficients_i[g*IntCoefWidth +: IntCoefWidth];
  end

  for (genvar g = 0; g < NumBool; g++) begin : g_bool
    assign boolean_variables_o[g] = |boolean_coefficients_i[g*BoolCoefWidth +: BoolCoefWidth];
  end

endmodule

// File: rtl/clause_variable_sequencer.sv
// Clause variable sequencer.
// Accepts one clause (integer + boolean coefficient vectors) on in_valid/in_ready, then emits
// the index of every present variable, one per out_valid/out_ready beat: integer variables in
// ascending order, then boolean variables in ascending order. A clause with no variables
// produces a single beat with out_empty_clause = 1.
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset.
//   in_integer_coefficients        : NI coefficients, coefficient i at [i*W +: W].
//   in_boolean_coefficients        : NB 2-bit coefficients, coefficient i at [i*2 +: 2].
//   in_valid / in_ready            : clause handshake (in_ready only in IDLE).
//   out_variable_index             : emitted variable index, zero-extended.
//   out_variable_is_boolean        : 0 = integer variable, 1 = boolean variable.
//   out_empty_clause, out_last     : empty-clause beat, final beat of the clause.
//   out_valid / out_ready          : beat handshake.
//   out_variable_count             : only with CLAUSE_VARIABLE_COUNT_EN; variables in the
//                                    last accepted clause.
module clause_variable_sequencer
  import clause_pkg::*;
#(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = BoolCoefWidth,
  localparam int unsigned IntBits = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
  localparam int unsigned BoolBits = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
  localparam int unsigned IntW = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
  localparam int unsigned BoolW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT,
  localparam int unsigned NI = 1 << IntBits,
  localparam int unsigned NB = 1 << BoolBits,
  localparam int unsigned IW = index_width(IntBits, BoolBits)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NI*IntW-1:0]  in_integer_coefficients,
  input  logic [NB*BoolW-1:0] in_boolean_coefficients,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IW-1:0]       out_variable_index,
  output logic                out_variable_is_boolean,
  output logic                out_empty_clause,
  output logic                out_last,
  output logic                out_valid,
`ifdef CLAUSE_VARIABLE_COUNT_EN
  output logic [count_width(IntBits, BoolBits)-1:0] out_variable_count,
`endif
  input  logic                out_ready
);

  localparam int unsigned NA       = NI + NB;
  localparam int unsigned IntIdxW  = (NI > 1) ? $clog2(NI) : 1;
  localparam int unsigned BoolIdxW = (NB > 1) ? $clog2(NB) : 1;

  state_e          state_q, state_d;
  logic [NI-1:0]   int_pend_q, int_pend_d, int_mask;
  logic [NB-1:0]   bool_pend_q, bool_pend_d, bool_mask;
  logic [IntIdxW-1:0]  int_idx;
  logic [BoolIdxW-1:0] bool_idx;
  logic            int_found, bool_found;
  logic [NA-1:0]   all_pend;
  logic            one_left;

  VariablesDetector #(
    .IntIdxBits   (IntBits),
    .BoolIdxBits  (BoolBits),
    .IntCoefWidth (IntW),
    .BoolCoefWidth(BoolW)
  ) u_detector (
    .integer_coefficients_i(in_integer_coefficients),
    .boolean_coefficients_i(in_boolean_coefficients),
    .integer_variables_o   (int_mask),
    .boolean_variables_o   (bool_mask)
  );

  lsb_priority_encoder #(
    .N   (NI),
    .IdxW(IntIdxW)
  ) u_int_enc (
    .req_i  (int_pend_q),
    .index_o(int_idx),
    .found_o(int_found)
  );

  lsb_priority_encoder #(
    .N   (NB),
    .IdxW(BoolIdxW)
  ) u_bool_enc (
    .req_i  (bool_pend_q),
    .index_o(bool_idx),
    .found_o(bool_found)
  );

  // Exactly one pending bit: x != 0 and x & (x-1) == 0.
  assign all_pend = {bool_pend_q, int_pend_q};
  assign one_left = (|all_pend) && ~|(all_pend & (all_pend - NA'(1)));

`ifdef CLAUSE_VARIABLE_COUNT_EN
  localparam int unsigned CW = count_width(IntBits, BoolBits);
  logic [CW-1:0] count_q, count_d;
  assign out_variable_count = count_q;
`endif

  always_comb begin
    state_d                 = state_q;
    int_pend_d              = int_pend_q;
    bool_pend_d             = bool_pend_q;
    in_ready                = 1'b0;
    out_valid               = 1'b0;
    out_variable_index      = '0;
    out_variable_is_boolean = 1'b0;
    out_empty_clause        = 1'b0;
    out_last                = 1'b0;
`ifdef CLAUSE_VARIABLE_COUNT_EN
    count_d                 = count_q;
`endif
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          int_pend_d  = int_mask;
          bool_pend_d = bool_mask;
          state_d     = (|int_mask || |bool_mask) ? StEmit : StLastEmpty;
`ifdef CLAUSE_VARIABLE_COUNT_EN
          count_d     = CW'($countones({bool_mask, int_mask}));
`endif
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        out_last  = one_left;
        if (int_found) begin
          out_variable_index = IW'(int_idx);
        end else if (bool_found) begin
          out_variable_index      = IW'(bool_idx);
          out_variable_is_boolean = 1'b1;
        end
        if (out_ready) begin
          // x & (x-1) drops the lowest set bit, i.e. the one just emitted.
          if (int_found) begin
            int_pend_d = int_pend_q & (int_pend_q - NI'(1));
          end else if (bool_found) begin
            bool_pend_d = bool_pend_q & (bool_pend_q - NB'(1));
          end
          if (one_left) begin
            state_d = StIdle;
          end
        end
      end
      StLastEmpty: begin
        out_valid        = 1'b1;
        out_empty_clause = 1'b1;
        out_last         = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      int_pend_q  <= '0;
      bool_pend_q <= '0;
    end else begin
      state_q     <= state_d;
      int_pend_q  <= int_pend_d;
      bool_pend_q <= bool_pend_d;
    end
  end

`ifdef CLAUSE_VARIABLE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_clause_variable_sequencer.sv
// Bench for clause_variable_sequencer (default parameters: 2 integer slots of 4 bits,
// 2 boolean slots of 2 bits). A queue-of-beats model predicts the outputs each cycle;
// directed scenarios add literal expectations.
module tb_clause_variable_sequencer;

  localparam int NI = 2;
  localparam int NB = 2;
  localparam int W  = 4;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    in_ic;
  logic [3:0]    in_bc;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] out_variable_index;
  logic          out_variable_is_boolean;
  logic          out_empty_clause;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
`ifdef CLAUSE_VARIABLE_COUNT_EN
  logic [2:0]    out_variable_count;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  clause_variable_sequencer dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .in_integer_coefficients(in_ic),
    .in_boolean_coefficients(in_bc),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .out_variable_index     (out_variable_index),
    .out_variable_is_boolean(out_variable_is_boolean),
    .out_empty_clause       (out_empty_clause),
    .out_last               (out_last),
    .out_valid              (out_valid),
`ifdef CLAUSE_VARIABLE_COUNT_EN
    .out_variable_count     (out_variable_count),
`endif
    .out_ready              (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [IW-1:0] idx;
    logic          is_bool;
    logic          empty;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_cnt = 0;

  // Expand a clause into its full list of expected beats.
  task automatic model_accept(input logic [7:0] ic, input logic [3:0] bc);
    beat_t b;
    beat_t lst[$];
    for (int i = 0; i < NI; i++) begin
      if (ic[i*W +: W] != 0) begin
        b = '0;
        b.idx = IW'(i);
        lst.push_back(b);
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (bc[i*2 +: 2] != 0) begin
        b = '0;
        b.idx = IW'(i);
        b.is_bool = 1'b1;
        lst.push_back(b);
      end
    end
    if (lst.size() == 0) begin
      exp_cnt = 0;
      b = '0;
      b.empty = 1'b1;
      b.last = 1'b1;
      lst.push_back(b);
    end else begin
      exp_cnt = lst.size();
      b = lst.pop_back();
      b.last = 1'b1;
      lst.push_back(b);
    end
    exp_q = lst;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (exp_q.size() > 0) begin
      if (out_ready) void'(exp_q.pop_front());
    end else if (in_valid) begin
      model_accept(in_ic, in_bc);
    end
  end

  logic [5:0] cmp_act, cmp_exp;
  always @(negedge clk) begin
    cmp_act = {in_ready, out_valid, out_variable_index, out_variable_is_boolean,
               out_empty_clause, out_last};
    if (exp_q.size() > 0) cmp_exp = {1'b0, 1'b1, exp_q[0]};
    else cmp_exp = 6'b100000;
    check("model_cycle {rdy,vld,idx,bool,empty,last}", cmp_act, cmp_exp);
`ifdef CLAUSE_VARIABLE_COUNT_EN
    check("model_count", out_variable_count, exp_cnt);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic present(input logic [7:0] ic, input logic [3:0] bc);
    in_ic    = ic;
    in_bc    = bc;
    in_valid = 1'b1;
  endtask

  // Returns at a negedge with the DUT idle; optionally toggles out_ready meanwhile.
  task automatic wait_idle(input bit toggle);
    bit seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready && !out_valid) begin
        seen = 1'b1;
        break;
      end
      if (toggle) out_ready = ~out_ready;
    end
    if (!seen) check("wait_idle_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
  endtask

  logic [7:0] tbl_ic[4] = '{8'h0F, 8'h00, 8'hA5, 8'h01};
  logic [3:0] tbl_bc[4] = '{4'b0000, 4'b1100, 4'b0101, 4'b0001};

  initial begin
    reset_n   = 1'b0;
    in_ic     = '0;
    in_bc     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_outputs", {in_ready, out_valid, out_variable_index, out_variable_is_boolean,
                             out_empty_clause, out_last}, 6'b100000);
    end

    // Int slot 1 and bool slots 0,1.
    present(8'b0011_0000, 4'b01_11);
    @(negedge clk);
    check("s2_beat0 {vld,idx,bool,last}",
          {out_valid, out_variable_index, out_variable_is_boolean, out_last}, 4'b1100);
`ifdef CLAUSE_VARIABLE_COUNT_EN
    check("s2_count", out_variable_count, 3);
`endif
    in_valid = 1'b0;
    in_ic    = 8'hFF;  // must not affect the latched clause
    @(negedge clk);
    check("s2_beat1 {vld,idx,bool,last}",
          {out_valid, out_variable_index, out_variable_is_boolean, out_last}, 4'b1010);
    @(negedge clk);
    check("s2_beat2 {vld,idx,bool,last}",
          {out_valid, out_variable_index, out_variable_is_boolean, out_last}, 4'b1111);
    @(negedge clk);
    check("s2_ready_back {rdy,vld}", {in_ready, out_valid}, 2'b10);

    // Empty clause.
    present(8'h00, 4'b0000);
    @(negedge clk);
    check("s3_empty {vld,empty,last,idx}",
          {out_valid, out_empty_clause, out_last, out_variable_index}, 4'b1110);
`ifdef CLAUSE_VARIABLE_COUNT_EN
    check("s3_count", out_variable_count, 0);
`endif
    in_valid = 1'b0;
    @(negedge clk);

    // Back-pressure; a second clause is held on the input meanwhile.
    present(8'b0001_0001, 4'b0000);
    out_ready = 1'b0;
    @(negedge clk);
    check("s4_beat0 {vld,idx,bool,last}",
          {out_valid, out_variable_index, out_variable_is_boolean, out_last}, 4'b1000);
    present(8'h50, 4'b1000);
    @(negedge clk);
    check("s4_hold1 {rdy,vld,idx,bool,last}", {in_ready, out_valid, out_variable_index,
          out_variable_is_boolean, out_last}, 5'b01000);
    @(negedge clk);
    check("s4_hold2 {rdy,vld,idx,bool,last}", {in_ready, out_valid, out_variable_index,
          out_variable_is_boolean, out_last}, 5'b01000);
    out_ready = 1'b1;
    @(negedge clk);
    check("s4_beat1 {vld,idx,bool,last}",
          {out_valid, out_variable_index, out_variable_is_boolean, out_last}, 4'b1101);
    @(negedge clk);
    check("s4_idle_gap {rdy,vld}", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("s4_next_clause {vld,idx,bool,last}",
          {out_valid, out_variable_index, out_variable_is_boolean, out_last}, 4'b1100);
    wait_idle(1'b0);

    // Asynchronous reset during the second beat.
    present(8'b0011_0000, 4'b01_11);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("s5_async_reset {rdy,vld}", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    reset_n = 1'b1;
    present(8'b0011_0000, 4'b01_11);
    @(negedge clk);
    in_valid = 1'b0;
    check("s5_after_reset {vld,idx,bool,last}",
          {out_valid, out_variable_index, out_variable_is_boolean, out_last}, 4'b1100);
    wait_idle(1'b0);

    // Mixed clauses with out_ready toggling; model checks every cycle.
    for (int k = 0; k < 4; k++) begin
      present(tbl_ic[k], tbl_bc[k]);
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
